// File: rtl/act_buf_pkg.sv
// Shared types for the multi-bank activation buffer.
package act_buf_pkg;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_READY = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_e;

endpackage

// File: rtl/act_lane_ram.sv
// One lane of one bank: simple dual-port RAM with registered read, no reset so it maps to block RAM.
module act_lane_ram #(
  parameter int ROWS       = 1024,
  parameter int ROW_W      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ROW_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ROW_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

  // write port and registered read port; rdata holds when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/act_buffer_multibank.sv
// N-bank activation buffer: the producer fills one bank while the consumer drains another.
// Words are lane-interleaved so a wide read touches every lane RAM of a bank exactly once.
module act_buffer_multibank
  import act_buf_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int DEPTH      = 16384,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_W     = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_valid_i,
  output logic                            wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]           wr_addr_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            wr_commit_i,
  output logic [BANK_W-1:0]               wr_bank_o,
  output logic                            wr_err_o,
  input  logic                            rd_req_i,
  input  logic                            rd_wide_i,
  input  logic [ADDR_WIDTH-1:0]           rd_addr_i,
  output logic                            rd_bank_ready_o,
  output logic [BANK_W-1:0]               rd_bank_o,
  output logic [ADDR_WIDTH:0]             rd_len_o,
  input  logic                            rd_release_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] rd_data_o,
  output logic                            rd_valid_o,
  output logic                            empty_o,
  output logic                            full_o
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int ROWS   = DEPTH / NUM_LANES;
  localparam int ROW_W  = ADDR_WIDTH - LANE_W;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  bank_state_e           state     [NUM_BANKS];
  bank_state_e           state_nxt [NUM_BANKS];
  logic [CNT_W-1:0]      len       [NUM_BANKS];
  logic [BANK_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fill_cnt, fill_inc;
  logic                  wr_in_range, wr_write, wr_err, wr_err_q;
  logic                  commit_fire, release_fire, rd_fire;
  logic [LANE_W-1:0]     lane_off  [NUM_LANES];
  logic [CNT_W-1:0]      lane_word [NUM_LANES];
  logic [ROW_W-1:0]      row_addr  [NUM_LANES];
  logic [LANE_W-1:0]     lane_sel  [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_ok_nxt, lane_ok_q;
  logic [DATA_WIDTH-1:0] ram_q [NUM_BANKS][NUM_LANES];
  logic [BANK_W-1:0]     rd_bank_q;
  logic [LANE_W-1:0]     rd_base_q;
  logic                  rd_valid_q;

  function automatic logic [BANK_W-1:0] ptr_next(input logic [BANK_W-1:0] p);
    return (p == LAST_BANK) ? '0 : p + BANK_W'(1);
  endfunction

  assign wr_bank_o  = wr_ptr;
  assign rd_bank_o  = rd_ptr;
  assign rd_len_o   = len[rd_ptr];
  assign wr_err_o   = wr_err_q;
  assign rd_valid_o = rd_valid_q;

  // handshake qualifiers and occupancy flags; READY/DRAIN banks hold data, FREE/FILL banks are writable
  always_comb begin
    wr_ready_o      = (state[wr_ptr] == BANK_FILL);
    rd_bank_ready_o = (state[rd_ptr] == BANK_DRAIN);
    empty_o = 1'b1;
    full_o  = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state[b] == BANK_READY || state[b] == BANK_DRAIN) empty_o = 1'b0;
      else full_o = 1'b0;
    end
    wr_in_range  = ({1'b0, wr_addr_i} < DEPTH_C);
    wr_write     = wr_valid_i & wr_ready_o & wr_in_range;
    wr_err       = wr_valid_i & wr_ready_o & ~wr_in_range;
    fill_inc     = (wr_write && fill_cnt != DEPTH_C) ? fill_cnt + CNT_W'(1) : fill_cnt;
    commit_fire  = wr_commit_i & wr_ready_o;
    release_fire = rd_release_i & rd_bank_ready_o;
    rd_fire      = rd_req_i & rd_bank_ready_o;
  end

  // per-bank ownership next state
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_nxt[b] = state[b];
      case (state[b])
        BANK_FREE:  if (BANK_W'(b) == wr_ptr) state_nxt[b] = BANK_FILL; else state_nxt[b] = BANK_FREE;
        BANK_FILL:  if (commit_fire && BANK_W'(b) == wr_ptr) state_nxt[b] = BANK_READY; else state_nxt[b] = BANK_FILL;
        BANK_READY: if (BANK_W'(b) == rd_ptr) state_nxt[b] = BANK_DRAIN; else state_nxt[b] = BANK_READY;
        BANK_DRAIN: if (release_fire && BANK_W'(b) == rd_ptr) state_nxt[b] = BANK_FREE; else state_nxt[b] = BANK_DRAIN;
        default:    state_nxt[b] = BANK_FREE;
      endcase
    end
  end

  // bank states, pointers, fill counter and recorded lengths
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state[b] <= BANK_FREE;
        len[b]   <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state[b] <= state_nxt[b];
        if (commit_fire && BANK_W'(b) == wr_ptr) len[b] <= fill_inc;
      end
      if (commit_fire) begin
        wr_ptr   <= ptr_next(wr_ptr);
        fill_cnt <= '0;
      end else begin
        fill_cnt <= fill_inc;
      end
      if (release_fire) rd_ptr <= ptr_next(rd_ptr);
      wr_err_q <= wr_err;
    end
  end

  // lane RAM l holds the one word of addr..addr+NUM_LANES-1 whose residue is l
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_off[l]  = LANE_W'(l) - rd_addr_i[LANE_W-1:0];
      lane_word[l] = {1'b0, rd_addr_i} + {{(CNT_W-LANE_W){1'b0}}, lane_off[l]};
      row_addr[l]  = ROW_W'(lane_word[l] >> LANE_W);
      if (rd_wide_i) lane_ok_nxt[l] = (({1'b0, rd_addr_i} + CNT_W'(l)) < DEPTH_C);
      else lane_ok_nxt[l] = (l == 0) && ({1'b0, rd_addr_i} < DEPTH_C);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [DATA_WIDTH-1:0] q;
      act_lane_ram #(.ROWS(ROWS), .ROW_W(ROW_W), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk   (clk_i),
        .we    (wr_write && (wr_ptr == BANK_W'(b)) && (wr_addr_i[LANE_W-1:0] == LANE_W'(l))),
        .waddr (wr_addr_i[ADDR_WIDTH-1:LANE_W]),
        .wdata (wr_data_i),
        .re    (rd_fire && (rd_ptr == BANK_W'(b))),
        .raddr (row_addr[l]),
        .rdata (q)
      );
      assign ram_q[b][l] = q;
    end
  end

  // read pipeline: bank, rotation and lane mask are kept until the next accepted read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
      rd_base_q  <= '0;
      lane_ok_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_bank_q <= rd_ptr;
        rd_base_q <= rd_addr_i[LANE_W-1:0];
        lane_ok_q <= lane_ok_nxt;
      end
    end
  end

  // rotate lane RAM outputs so output lane i carries word addr+i
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_sel[i] = rd_base_q + LANE_W'(i);
      if (lane_ok_q[i]) rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = ram_q[rd_bank_q][lane_sel[i]];
      else rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

endmodule
